hb_pulse_conditioner: RTL and testbench

Front-end stage of the heartbeat counter. It synchronises and debounces the raw heart_pulse input, applies a refractory window, and emits one clean single-cycle beat strobe per heartbeat. It also measures the beat-to-beat period in clock cycles and drives the 100-cycle LED/buzzer alert. period_count is the index consumed by the downstream BPM lookup table and BCD display path.

---
 rtl/hb_pulse_conditioner.sv | 150 +++++++++++++++
 tb/tb_hb_pulse_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hb_pulse_conditioner.sv
// Heartbeat front end: synchronises and debounces the raw sensor pulse,
// enforces a refractory window after each accepted beat, emits a one-cycle
// beat strobe, measures beat-to-beat period and drives the LED/buzzer alert.
//
// Period FSM
//   state     | meaning
//   S_IDLE    | no reference beat yet (after reset)
//   S_RUN     | reference beat taken, elapsed count running
//   S_TIMEOUT | MAX_PERIOD cycles without a beat, elapsed count frozen
module hb_pulse_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int REFRACTORY_CYCLES = 200,
  parameter int ALERT_CYCLES      = 100,
  parameter int PERIOD_W          = 11,
  parameter int MAX_PERIOD        = 2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                heart_pulse,
  input  logic                mute,
  output logic                beat_strobe,
  output logic [PERIOD_W-1:0] period_count,
  output logic                period_valid,
  output logic                timeout,
  output logic                LED,
  output logic                buzzer
);

  localparam int REFR_W  = (REFRACTORY_CYCLES > 0) ? $clog2(REFRACTORY_CYCLES + 1) : 1;
  localparam int ALERT_W = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;

  localparam logic [REFR_W-1:0]   REFR_LOAD  = REFR_W'(REFRACTORY_CYCLES);
  localparam logic [ALERT_W-1:0]  ALERT_LOAD = ALERT_W'(ALERT_CYCLES - 1);
  localparam logic [3:0]          DB_LAST    = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] MAX_P      = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE_P      = PERIOD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_TIMEOUT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt;
  logic                   filt_d;
  logic [3:0]             db_cnt;
  logic [REFR_W-1:0]      refr_cnt;
  logic                   rise;
  logic                   accept;
  state_t                 state;
  logic [PERIOD_W-1:0]    elapsed;
  logic [ALERT_W-1:0]     alert_cnt;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = filt & ~filt_d;
  assign accept   = rise & (refr_cnt == '0);

  // Input synchroniser: shift raw pulse through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], heart_pulse};
  end

  // Debounce: toggle filtered level after DEBOUNCE_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt   <= 1'b0;
      db_cnt <= 4'd0;
    end else if (sync_out != filt) begin
      if (db_cnt == DB_LAST) begin
        filt   <= ~filt;
        db_cnt <= 4'd0;
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
    end else begin
      db_cnt <= 4'd0;
    end
  end

  // Edge accept and refractory down-counter; rising edges inside the window are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_d      <= 1'b0;
      beat_strobe <= 1'b0;
      refr_cnt    <= '0;
    end else begin
      filt_d      <= filt;
      beat_strobe <= accept;
      if (accept)               refr_cnt <= REFR_LOAD;
      else if (refr_cnt != '0)  refr_cnt <= refr_cnt - 1'b1;
    end
  end

  // Period FSM: elapsed holds cycles since the last accepted beat, so the
  // value seen on the next accept edge is the beat-to-beat distance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      elapsed      <= '0;
      period_count <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_TIMEOUT: begin
          if (accept) begin
            state   <= S_RUN;
            elapsed <= ONE_P;
            timeout <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            period_count <= elapsed;
            period_valid <= 1'b1;
            elapsed      <= ONE_P;
          end else if (elapsed >= MAX_P) begin
            state        <= S_TIMEOUT;
            timeout      <= 1'b1;
            period_valid <= 1'b0;
          end else begin
            elapsed <= elapsed + ONE_P;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Alert window: LED on for ALERT_CYCLES after each strobe, restarted by a new strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LED       <= 1'b0;
      alert_cnt <= '0;
    end else if (beat_strobe) begin
      LED       <= 1'b1;
      alert_cnt <= ALERT_LOAD;
    end else if (LED) begin
      if (alert_cnt == '0) LED <= 1'b0;
      else                 alert_cnt <= alert_cnt - 1'b1;
    end
  end

  assign buzzer = LED & ~mute;

endmodule

// File: tb/tb_hb_pulse_conditioner.sv
// Bench for hb_pulse_conditioner: directed pulses with hand-computed
// expected strobe cycles and periods pushed to a scoreboard queue; a
// negedge monitor pops and compares on every beat_strobe.
module tb_hb_pulse_conditioner;

  localparam int PW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          heart_pulse = 1'b0;
  logic          mute = 1'b0;
  logic          beat_strobe;
  logic [PW-1:0] period_count;
  logic          period_valid;
  logic          timeout;
  logic          LED;
  logic          buzzer;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int pc;
    bit valid;
  } exp_t;

  exp_t exp_q[$];

  hb_pulse_conditioner dut (
    .clk          (clk),
    .reset        (reset),
    .heart_pulse  (heart_pulse),
    .mute         (mute),
    .beat_strobe  (beat_strobe),
    .period_count (period_count),
    .period_valid (period_valid),
    .timeout      (timeout),
    .LED          (LED),
    .buzzer       (buzzer)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the next expected beat.
  always @(negedge clk) begin
    exp_t e;
    if (beat_strobe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe at cycle %0d: got strobe expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("period_count", int'(period_count), e.pc);
        chk("period_valid", int'(period_valid), int'(e.valid));
        chk("timeout_at_beat", int'(timeout), 0);
      end
    end
    if (!reset) chk("buzzer_gate", int'(buzzer), int'(LED & ~mute));
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive a pulse starting at negedge cycle t; strobe expected at t+7.
  task automatic pulse_at(input int t, input int w, input bit expect_beat,
                          input int pc, input bit valid);
    exp_t e;
    wait_until(t);
    if (expect_beat) begin
      e.cyc = t + 7;
      e.pc = pc;
      e.valid = valid;
      exp_q.push_back(e);
    end
    heart_pulse = 1'b1;
    repeat (w) @(negedge clk);
    heart_pulse = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobe"}, int'(beat_strobe), 0);
    chk({tag, "_pc"}, int'(period_count), 0);
    chk({tag, "_valid"}, int'(period_valid), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_led"}, int'(LED), 0);
    chk({tag, "_buzzer"}, int'(buzzer), 0);
  endtask

  int t1, b, c, s, d, f, g, r;

  initial begin
    // ---- reset ----
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // ---- test 1: first beat, latency, LED width ----
    t1 = cyc;
    begin
      exp_t e;
      e.cyc = t1 + 7; e.pc = 0; e.valid = 1'b0;
      exp_q.push_back(e);
    end
    heart_pulse = 1'b1;
    repeat (7) @(negedge clk);
    chk("led_at_strobe", int'(LED), 0);
    @(negedge clk);
    chk("led_first", int'(LED), 1);
    chk("buzzer_first", int'(buzzer), 1);
    repeat (12) @(negedge clk);
    heart_pulse = 1'b0;
    repeat (87) @(negedge clk);
    chk("led_last", int'(LED), 1);
    @(negedge clk);
    chk("led_off", int'(LED), 0);

    // ---- test 2: beats every 750 cycles ----
    pulse_at(t1 + 750,  20, 1'b1, 750, 1'b1);
    pulse_at(t1 + 1500, 20, 1'b1, 750, 1'b1);
    b = t1 + 2250;
    pulse_at(b, 20, 1'b1, 750, 1'b1);

    // ---- test 3: refractory drop, glitches, 250-cycle period ----
    pulse_at(b + 150, 20, 1'b0, 0, 1'b0);
    pulse_at(b + 300, 3,  1'b0, 0, 1'b0);
    pulse_at(b + 400, 3,  1'b0, 0, 1'b0);
    pulse_at(b + 750, 20, 1'b1, 750, 1'b1);
    pulse_at(b + 850, 3,  1'b0, 0, 1'b0);
    c = b + 1000;
    pulse_at(c, 20, 1'b1, 250, 1'b1);

    // ---- test 4: timeout exactly 2000 cycles after strobe ----
    s = c + 7;
    wait_until(s + 1999);
    chk("timeout_early", int'(timeout), 0);
    chk("valid_before_to", int'(period_valid), 1);
    @(negedge clk);
    chk("timeout_set", int'(timeout), 1);
    chk("valid_cleared", int'(period_valid), 0);
    chk("pc_held", int'(period_count), 250);
    d = s + 2500;
    pulse_at(d, 20, 1'b1, 250, 1'b0);
    chk("timeout_cleared", int'(timeout), 0);
    f = d + 600;
    pulse_at(f, 20, 1'b1, 600, 1'b1);

    // ---- test 5: beat lands exactly at MAX_PERIOD ----
    pulse_at(f + 2000, 20, 1'b1, 2000, 1'b1);
    chk("no_timeout_at_max", int'(timeout), 0);

    // ---- test 6: mute during LED, reset mid-LED and mid-period ----
    g = f + 2500;
    pulse_at(g, 10, 1'b1, 500, 1'b1);
    wait_until(g + 20);
    #2 mute = 1'b1;
    #1 chk("mute_led_on", int'(LED), 1);
    chk("mute_buzzer_off", int'(buzzer), 0);
    wait_until(g + 25);
    #2 mute = 1'b0;
    #1 chk("unmute_buzzer_on", int'(buzzer), 1);
    wait_until(g + 30);
    #2 mute = 1'b1;
    wait_until(g + 50);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    mute = 1'b0;
    reset = 1'b0;
    r = cyc;
    pulse_at(r + 10, 20, 1'b1, 0, 1'b0);
    pulse_at(r + 410, 20, 1'b1, 400, 1'b1);

    repeat (300) @(negedge clk);
    chk("missing_strobes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
